// File: rtl/onehot_seq_gen_if.sv
// Handshake/data bundle between a pattern source and the one-hot serial transmitter.
// The master drives requests and pattern fields; the slave (transmitter) drives the serial line.
interface onehot_seq_gen_if #(
    parameter int PAT_W = 8,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) ();
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [REP_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap;
    logic             out;
    logic             bit_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, repeat_cnt, gap,
        input  out, bit_valid, busy, done
    );

    modport slave (
        input  start, abort, pattern, repeat_cnt, gap,
        output out, bit_valid, busy, done
    );
endinterface

// File: rtl/onehot_seq_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB first, once plus repeat_cnt copies,
// separated by gap idle cycles. All outputs are registered functions of the next state.
module onehot_seq_gen #(
    parameter int PAT_W = 8,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    onehot_seq_gen_if.slave  bus
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_SEND = 4'b0010,
        S_GAP  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    // Kept as a raw vector so that non-one-hot values stay representable and fall to the default arm.
    logic [3:0]       r_state;
    logic [3:0]       w_state_nxt;
    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-1:0] w_pat_nxt;
    logic [REP_W-1:0] r_reps;
    logic [REP_W-1:0] w_reps_nxt;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_nxt;
    logic [GAP_W-1:0] r_gcnt;
    logic [GAP_W-1:0] w_gcnt_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_out;
    logic             r_bit_valid;
    logic             r_busy;
    logic             r_done;
    logic             w_out_nxt;
    logic             w_bit_valid_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // Next-state, counter and next-output logic.
    always_comb begin
        w_state_nxt = S_IDLE;
        w_pat_nxt   = r_pat;
        w_reps_nxt  = r_reps;
        w_gap_nxt   = r_gap;
        w_gcnt_nxt  = r_gcnt;
        w_idx_nxt   = r_idx;

        if (bus.abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = S_SEND;
                        w_pat_nxt   = bus.pattern;
                        w_reps_nxt  = bus.repeat_cnt;
                        w_gap_nxt   = bus.gap;
                        w_idx_nxt   = IDX_MAX;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_SEND: begin
                    if (r_idx == {IDX_W{1'b0}}) begin
                        if (r_reps == {REP_W{1'b0}}) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_reps_nxt = r_reps - REP_W'(1);
                            w_idx_nxt  = IDX_MAX;
                            if (r_gap == {GAP_W{1'b0}}) begin
                                w_state_nxt = S_SEND;
                            end else begin
                                // Loaded with gap-1 so the GAP state lasts exactly r_gap cycles.
                                w_state_nxt = S_GAP;
                                w_gcnt_nxt  = r_gap - GAP_W'(1);
                            end
                        end
                    end else begin
                        w_state_nxt = S_SEND;
                        w_idx_nxt   = r_idx - IDX_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_gcnt == {GAP_W{1'b0}}) begin
                        w_state_nxt = S_SEND;
                        w_idx_nxt   = IDX_MAX;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_gcnt_nxt  = r_gcnt - GAP_W'(1);
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        w_out_nxt       = (w_state_nxt == S_SEND) ? w_pat_nxt[w_idx_nxt] : 1'b0;
        w_bit_valid_nxt = (w_state_nxt == S_SEND);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_done_nxt      = (w_state_nxt == S_DONE);
    end

    // State, capture registers and output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pat       <= {PAT_W{1'b0}};
            r_reps      <= {REP_W{1'b0}};
            r_gap       <= {GAP_W{1'b0}};
            r_gcnt      <= {GAP_W{1'b0}};
            r_idx       <= {IDX_W{1'b0}};
            r_out       <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pat       <= w_pat_nxt;
            r_reps      <= w_reps_nxt;
            r_gap       <= w_gap_nxt;
            r_gcnt      <= w_gcnt_nxt;
            r_idx       <= w_idx_nxt;
            r_out       <= w_out_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.out       = r_out;
    assign bus.bit_valid = r_bit_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
